// File: rtl/sdram_port_arb4_if.sv
// Controller-side port bundle of the four-client SDRAM arbiter: one write and one read
// request/ack channel plus the controller's init-done flag.
interface sdram_port_arb4_if;
    logic        sdram_init_done;
    logic        sdram_wr_req;
    logic        sdram_wr_ack;
    logic [23:0] sdram_wr_addr;
    logic [9:0]  sdram_wr_burst;
    logic [15:0] sdram_din;
    logic        sdram_rd_req;
    logic        sdram_rd_ack;
    logic [23:0] sdram_rd_addr;
    logic [9:0]  sdram_rd_burst;

    modport master (
        input  sdram_init_done, sdram_wr_ack, sdram_rd_ack,
        output sdram_wr_req, sdram_wr_addr, sdram_wr_burst, sdram_din,
        output sdram_rd_req, sdram_rd_addr, sdram_rd_burst
    );

    modport slave (
        output sdram_init_done, sdram_wr_ack, sdram_rd_ack,
        input  sdram_wr_req, sdram_wr_addr, sdram_wr_burst, sdram_din,
        input  sdram_rd_req, sdram_rd_addr, sdram_rd_burst
    );
endinterface

// File: rtl/sdram_port_arb4.sv
// Four-client round-robin burst arbiter in front of one SDRAM write/read port pair.
// Optional SDRAM_ARB_RD_PRIO_EN: read slots take strict priority over write slots.
module sdram_port_arb4 #(
    parameter int BURST_LEN    = 256,
    parameter int REGION_WORDS = 384000,
    parameter int LVL_W        = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4*LVL_W-1:0] wr_level,
    input  logic [4*LVL_W-1:0] rd_room,
    input  logic [3:0]         rd_en,
    input  logic [3:0]         wr_clr,
    input  logic [3:0]         rd_clr,
    input  logic [63:0]        wr_data,
    output logic [3:0]         wr_pop,
    output logic [3:0]         rd_push,
    sdram_port_arb4_if.master  sdram
);

    typedef enum logic [2:0] {IDLE, GRANT, WREQ, WDATA, RREQ, RDATA, DONE} state_t;

    state_t           state_reg, state_next;
    logic [2:0]       slot_reg;
    logic [23:0]      wr_addr_reg, rd_addr_reg;
    logic [7:0]       elig;
    logic [2:0]       sel_slot;
    logic             sel_valid;
    logic [3:0][21:0] wr_ptr_all, rd_ptr_all;
    logic [3:0][15:0] client_data;
    logic             own_valid;
    logic [2:0]       own_slot;
    logic             done_cyc;

`ifdef SDRAM_ARB_RD_PRIO_EN
    logic [1:0] rr_wr_reg, rr_rd_reg;
`else
    logic [2:0] rr_reg;
`endif

    function automatic logic [21:0] ptr_advance(input logic [21:0] ptr);
        logic [22:0] sum;
        sum = {1'b0, ptr} + 23'(BURST_LEN);
        return (sum >= 23'(REGION_WORDS)) ? 22'd0 : sum[21:0];
    endfunction

    // In GRANT the slot being latched already owns its pointers, so a clear that
    // lands in that cycle is deferred rather than lost.
    assign own_valid = (state_reg != IDLE) && ((state_reg != GRANT) || sel_valid);
    assign own_slot  = (state_reg == GRANT) ? sel_slot : slot_reg;
    assign done_cyc  = (state_reg == DONE);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_client
            logic [21:0] wr_ptr_reg, rd_ptr_reg;
            logic        wr_pend_reg, rd_pend_reg;
            logic        wr_own, rd_own;

            assign elig[2*gi]      = 32'(wr_level[gi*LVL_W +: LVL_W]) >= BURST_LEN;
            assign elig[2*gi+1]    = rd_en[gi] && (32'(rd_room[gi*LVL_W +: LVL_W]) >= BURST_LEN);
            assign client_data[gi] = wr_data[16*gi +: 16];
            assign wr_own          = own_valid && (own_slot == 3'(2*gi));
            assign rd_own          = own_valid && (own_slot == 3'(2*gi+1));
            assign wr_ptr_all[gi]  = wr_ptr_reg;
            assign rd_ptr_all[gi]  = rd_ptr_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    wr_ptr_reg  <= '0;
                    wr_pend_reg <= 1'b0;
                end else if (done_cyc && wr_own) begin
                    wr_pend_reg <= 1'b0;
                    wr_ptr_reg  <= (wr_clr[gi] || wr_pend_reg) ? 22'd0 : ptr_advance(wr_ptr_reg);
                end else if (wr_clr[gi]) begin
                    if (wr_own) wr_pend_reg <= 1'b1;
                    else        wr_ptr_reg  <= '0;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_ptr_reg  <= '0;
                    rd_pend_reg <= 1'b0;
                end else if (done_cyc && rd_own) begin
                    rd_pend_reg <= 1'b0;
                    rd_ptr_reg  <= (rd_clr[gi] || rd_pend_reg) ? 22'd0 : ptr_advance(rd_ptr_reg);
                end else if (rd_clr[gi]) begin
                    if (rd_own) rd_pend_reg <= 1'b1;
                    else        rd_ptr_reg  <= '0;
                end
            end
        end
    endgenerate

    // Slot picker: slot 2i is client i write, slot 2i+1 is client i read.
    always_comb begin
        sel_slot  = 3'd0;
        sel_valid = 1'b0;
`ifdef SDRAM_ARB_RD_PRIO_EN
        for (int k = 3; k >= 0; k--) begin
            if (elig[{rr_wr_reg + 2'(k), 1'b0}]) begin
                sel_slot  = {rr_wr_reg + 2'(k), 1'b0};
                sel_valid = 1'b1;
            end
        end
        // Any eligible read overrides the write choice.
        for (int k = 3; k >= 0; k--) begin
            if (elig[{rr_rd_reg + 2'(k), 1'b1}]) begin
                sel_slot  = {rr_rd_reg + 2'(k), 1'b1};
                sel_valid = 1'b1;
            end
        end
`else
        for (int k = 7; k >= 0; k--) begin
            if (elig[rr_reg + 3'(k)]) begin
                sel_slot  = rr_reg + 3'(k);
                sel_valid = 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_reg    <= '0;
            wr_addr_reg <= '0;
            rd_addr_reg <= '0;
`ifdef SDRAM_ARB_RD_PRIO_EN
            rr_wr_reg   <= '0;
            rr_rd_reg   <= '0;
`else
            rr_reg      <= '0;
`endif
        end else if (state_reg == GRANT && sel_valid) begin
            slot_reg <= sel_slot;
            if (sel_slot[0]) rd_addr_reg <= {sel_slot[2:1], rd_ptr_all[sel_slot[2:1]]};
            else             wr_addr_reg <= {sel_slot[2:1], wr_ptr_all[sel_slot[2:1]]};
`ifdef SDRAM_ARB_RD_PRIO_EN
            if (sel_slot[0]) rr_rd_reg <= sel_slot[2:1] + 2'd1;
            else             rr_wr_reg <= sel_slot[2:1] + 2'd1;
`else
            rr_reg <= sel_slot + 3'd1;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (sdram.sdram_init_done && |elig) state_next = GRANT;
            GRANT: begin
                if (sdram.sdram_init_done && sel_valid) state_next = sel_slot[0] ? RREQ : WREQ;
                else                                    state_next = IDLE;
            end
            WREQ:    if (sdram.sdram_wr_ack)  state_next = WDATA;
            WDATA:   if (!sdram.sdram_wr_ack) state_next = DONE;
            RREQ:    if (sdram.sdram_rd_ack)  state_next = RDATA;
            RDATA:   if (!sdram.sdram_rd_ack) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sdram.sdram_wr_req = (state_reg == WREQ);
        sdram.sdram_rd_req = (state_reg == RREQ);
        sdram.sdram_din    = '0;
        wr_pop             = '0;
        rd_push            = '0;
        case (state_reg)
            WREQ, WDATA: wr_pop[slot_reg[2:1]]  = sdram.sdram_wr_ack;
            RREQ, RDATA: rd_push[slot_reg[2:1]] = sdram.sdram_rd_ack;
            default: ;
        endcase
        if (!slot_reg[0] && (state_reg == WREQ || state_reg == WDATA || state_reg == DONE))
            sdram.sdram_din = client_data[slot_reg[2:1]];
    end

    assign sdram.sdram_wr_addr  = wr_addr_reg;
    assign sdram.sdram_rd_addr  = rd_addr_reg;
    assign sdram.sdram_wr_burst = 10'(BURST_LEN);
    assign sdram.sdram_rd_burst = 10'(BURST_LEN);

endmodule

// File: tb/tb_sdram_port_arb4.sv
// Directed bench for sdram_port_arb4: behavioural controller model, strobe counters and a
// grant log checked against hand-computed slot/address sequences.
module tb_sdram_port_arb4;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [39:0] wr_level = '0;
    logic [39:0] rd_room = '0;
    logic [3:0]  rd_en = '0, wr_clr = '0, rd_clr = '0;
    logic [63:0] wr_data = 64'h4444_3333_2222_1111;
    logic [3:0]  wr_pop, rd_push;

    int          checks = 0;
    int          errors = 0;
    int          ack_len = 256;
    logic        clr_cnt = 1'b0;
    int          pop_cnt[4];
    int          push_cnt[4];
    logic [2:0]  slot_q[$];
    logic [23:0] addr_q[$];
    logic        prev_wr = 1'b0, prev_rd = 1'b0;

    sdram_port_arb4_if bus();

    sdram_port_arb4 #(.BURST_LEN(256), .REGION_WORDS(512), .LVL_W(10)) dut (
        .clk(clk), .rst(rst), .wr_level(wr_level), .rd_room(rd_room), .rd_en(rd_en),
        .wr_clr(wr_clr), .rd_clr(rd_clr), .wr_data(wr_data), .wr_pop(wr_pop),
        .rd_push(rd_push), .sdram(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] get_addr(input int i);
        return (i < addr_q.size()) ? addr_q[i] : 24'hFFFFFF;
    endfunction

    function automatic logic [3:0] get_slot(input int i);
        return (i < slot_q.size()) ? {1'b0, slot_q[i]} : 4'hF;
    endfunction

    task automatic wait_grants(input int n);
        int t = 0;
        while (slot_q.size() < n && t < n * 400 + 400) begin
            tick();
            t++;
        end
        check("grant_cnt", slot_q.size(), n);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wr_level = '0;
        rd_room = '0;
        rd_en = '0;
        wr_clr = '0;
        rd_clr = '0;
        repeat (3) tick();
        rst = 1'b0;
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
    endtask

    // Strobe counters and grant log; a grant is the rising edge of either request.
    always @(negedge clk) begin
        if (clr_cnt) begin
            for (int i = 0; i < 4; i++) begin
                pop_cnt[i] = 0;
                push_cnt[i] = 0;
            end
            slot_q.delete();
            addr_q.delete();
        end else begin
            for (int i = 0; i < 4; i++) begin
                pop_cnt[i] += int'(wr_pop[i]);
                push_cnt[i] += int'(rd_push[i]);
            end
            if (bus.sdram_wr_req && !prev_wr) begin
                slot_q.push_back({bus.sdram_wr_addr[23:22], 1'b0});
                addr_q.push_back(bus.sdram_wr_addr);
            end
            if (bus.sdram_rd_req && !prev_rd) begin
                slot_q.push_back({bus.sdram_rd_addr[23:22], 1'b1});
                addr_q.push_back(bus.sdram_rd_addr);
            end
        end
        prev_wr = bus.sdram_wr_req;
        prev_rd = bus.sdram_rd_req;
    end

    // Controller model: answer a request two cycles later with ack_len ack cycles.
    initial begin
        logic is_wr;
        bus.sdram_wr_ack = 1'b0;
        bus.sdram_rd_ack = 1'b0;
        forever begin
            tick();
            if (!rst && (bus.sdram_wr_req || bus.sdram_rd_req)) begin
                is_wr = bus.sdram_wr_req;
                repeat (2) tick();
                if (is_wr) bus.sdram_wr_ack = 1'b1;
                else       bus.sdram_rd_ack = 1'b1;
                for (int k = 0; k < ack_len; k++) begin
                    tick();
                    if (rst) break;
                end
                bus.sdram_wr_ack = 1'b0;
                bus.sdram_rd_ack = 1'b0;
            end
        end
    end

    initial begin
        int n;
        bus.sdram_init_done = 1'b0;
        do_reset();

        // Reset state
        check("rst_wr_req", bus.sdram_wr_req, 0);
        check("rst_rd_req", bus.sdram_rd_req, 0);
        check("rst_wr_burst", bus.sdram_wr_burst, 10'd256);
        check("rst_rd_burst", bus.sdram_rd_burst, 10'd256);
        check("rst_strobes", {wr_pop, rd_push}, 0);
        check("rst_addr", {bus.sdram_wr_addr, 8'h00} | bus.sdram_rd_addr, 0);
        check("rst_din", bus.sdram_din, 0);

        // Init gating
        wr_level[9:0] = 10'd300;
        repeat (20) tick();
        check("init_gate_grants", slot_q.size(), 0);
        check("init_gate_req", bus.sdram_wr_req, 0);
        bus.sdram_init_done = 1'b1;
        n = 0;
        while (!bus.sdram_wr_req && n < 10) begin
            tick();
            n++;
        end
        check("init_latency", n, 2);
        check("init_addr", bus.sdram_wr_addr, 24'h000000);

        // Client 2 write: burst length, data steering, next address
        do_reset();
        wr_level[29:20] = 10'd300;
        wait_grants(1);
        check("c2_slot", get_slot(0), 4'd4);
        check("c2_addr0", get_addr(0), 24'h800000);
        repeat (3) tick();
        check("c2_din", bus.sdram_din, 16'h3333);
        wait_grants(2);
        wr_level = '0;
        check("c2_pops", pop_cnt[2], 256);
        check("c2_other_pops", pop_cnt[0] + pop_cnt[1] + pop_cnt[3], 0);
        check("c2_addr1", get_addr(1), 24'h800100);

        // Client 1 read wrap inside a 512-word region
        do_reset();
        rd_en[1] = 1'b1;
        rd_room[19:10] = 10'd300;
        wait_grants(4);
        rd_room = '0;
        check("wrap_addr0", get_addr(0), 24'h400000);
        check("wrap_addr1", get_addr(1), 24'h400100);
        check("wrap_addr2", get_addr(2), 24'h400000);
        check("wrap_addr3", get_addr(3), 24'h400100);
        n = 0;
        while (push_cnt[1] < 1024 && n < 600) begin
            tick();
            n++;
        end
        repeat (5) tick();
        check("wrap_pushes", push_cnt[1], 1024);

        // Fairness with all eight slots eligible
        do_reset();
        wr_level = {4{10'd300}};
        rd_room = {4{10'd300}};
        rd_en = 4'hF;
        wait_grants(9);
        wr_level = '0;
        rd_room = '0;
        for (int i = 0; i < 9; i++) begin
`ifdef SDRAM_ARB_RD_PRIO_EN
            check($sformatf("fair_slot%0d", i), get_slot(i), 4'(2 * (i % 4) + 1));
`else
            check($sformatf("fair_slot%0d", i), get_slot(i), 4'(i % 8));
`endif
        end

        // Short burst: pointer still advances
        do_reset();
        ack_len = 100;
        wr_level[9:0] = 10'd300;
        wait_grants(2);
        wr_level = '0;
        check("short_pops", pop_cnt[0], 100);
        check("short_addr1", get_addr(1), 24'h000100);
        ack_len = 256;

        // Read clear during client 3 data phase
        do_reset();
        rd_en[3] = 1'b1;
        rd_room[39:30] = 10'd300;
        wait_grants(1);
        check("clr_addr0", get_addr(0), 24'hC00000);
        n = 0;
        while (push_cnt[3] < 10 && n < 100) begin
            tick();
            n++;
        end
        rd_clr[3] = 1'b1;
        tick();
        rd_clr[3] = 1'b0;
        wait_grants(2);
        rd_room = '0;
        check("clr_addr1", get_addr(1), 24'hC00000);

        // wr0 against rd1
        do_reset();
        wr_level[9:0] = 10'd300;
        rd_en[1] = 1'b1;
        rd_room[19:10] = 10'd300;
        wait_grants(1);
`ifdef SDRAM_ARB_RD_PRIO_EN
        check("prio_first", get_slot(0), 4'd3);
`else
        check("prio_first", get_slot(0), 4'd0);
`endif
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
